// File: rtl/memory_fill_verify_engine.sv
// Fills a word range of system memory with a constant or incrementing
// pattern, then optionally reads it back and counts mismatching words.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   start, abort     command strobe (IDLE only), synchronous abort
//   cmd_base/len     first word address, number of words (0..2**ADDR_W)
//   cmd_pattern      fill value or seed
//   cmd_incr         word i = pattern + i instead of a constant pattern
//   cmd_verify       read back and compare after the fill
//   busy, done       command in flight, one-cycle completion pulse
//   err_count        saturating mismatch count of the last verify
//   mem_*            Avalon slave port of the memory; readdata has 1-cycle latency
module memory_fill_verify_engine #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     cmd_base,
    input  logic [CNT_W-1:0]      cmd_len,
    input  logic [DATA_W-1:0]     cmd_pattern,
    input  logic                  cmd_incr,
    input  logic                  cmd_verify,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      err_count,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    idx, idx_n;
    logic [ADDR_W-1:0]   base_q, cur_base;
    logic [CNT_W-1:0]    len_q;
    logic [DATA_W-1:0]   pat_q, cur_pat;
    logic                incr_q, cur_incr, verify_q;
    logic                accept, last;
    logic                cmp_vld;
    logic [DATA_W-1:0]   cmp_exp;

    logic                busy_n, done_n, cs_n, we_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   wd_n;

    function automatic logic [DATA_W-1:0] word_at(
        input logic [DATA_W-1:0] pat,
        input logic              inc,
        input logic [CNT_W-1:0]  i
    );
        return pat + (inc ? DATA_W'(i) : '0);
    endfunction

    assign accept = (state == S_IDLE) && start && !abort;
    assign last   = (idx == len_q - 1'b1);

    // The registered outputs are decoded from the next state, so the
    // first write appears on the edge that accepts start; cmd fields are
    // used directly on that edge because the latches are not loaded yet.
    assign cur_base = (state == S_IDLE) ? cmd_base    : base_q;
    assign cur_pat  = (state == S_IDLE) ? cmd_pattern : pat_q;
    assign cur_incr = (state == S_IDLE) ? cmd_incr    : incr_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        idx_n   = idx;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        idx_n   = '0;
                        state_n = (cmd_len == '0) ? S_DONE : S_FILL;
                    end
                end
                S_FILL: begin
                    if (last) begin
                        idx_n   = '0;
                        state_n = verify_q ? S_READ : S_DONE;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
                S_READ: begin
                    if (last) state_n = S_DRAIN;
                    else      idx_n   = idx + 1'b1;
                end
                S_DRAIN: state_n = S_DONE;
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Output decode of the upcoming cycle
    always_comb begin
        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_DONE);
        cs_n   = (state_n == S_FILL) || (state_n == S_READ);
        we_n   = (state_n == S_FILL);
        addr_n = cs_n ? cur_base + idx_n[ADDR_W-1:0] : '0;
        wd_n   = we_n ? word_at(cur_pat, cur_incr, idx_n) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_clken      <= 1'b0;
            mem_byteenable <= '0;
            mem_address    <= '0;
            mem_writedata  <= '0;
        end else begin
            busy           <= busy_n;
            done           <= done_n;
            mem_chipselect <= cs_n;
            mem_write      <= we_n;
            mem_clken      <= busy_n;
            mem_byteenable <= cs_n ? '1 : '0;
            mem_address    <= addr_n;
            mem_writedata  <= wd_n;
        end
    end

    // Command latch and read-back compare; the expected word trails the
    // address by one cycle to line up with mem_readdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q    <= '0;
            len_q     <= '0;
            pat_q     <= '0;
            incr_q    <= 1'b0;
            verify_q  <= 1'b0;
            cmp_vld   <= 1'b0;
            cmp_exp   <= '0;
            err_count <= '0;
        end else begin
            cmp_vld <= !abort && (state == S_READ);
            cmp_exp <= word_at(pat_q, incr_q, idx);
            if (accept) begin
                base_q    <= cmd_base;
                len_q     <= cmd_len;
                pat_q     <= cmd_pattern;
                incr_q    <= cmd_incr;
                verify_q  <= cmd_verify;
                err_count <= '0;
            end else if (!abort && cmp_vld && mem_readdata != cmp_exp
                         && err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_fill_verify_engine.sv
// Bench for memory_fill_verify_engine: per-cycle expected bus activity
// is built from the command, with a simple memory model attached.
module tb_memory_fill_verify_engine;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int CW = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, abort;
    logic [AW-1:0] cmd_base;
    logic [CW-1:0] cmd_len;
    logic [DW-1:0] cmd_pattern;
    logic          cmd_incr, cmd_verify;
    logic          busy, done;
    logic [CW-1:0] err_count;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata, mem_readdata;

    always #5 clk = ~clk;

    memory_fill_verify_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .cmd_pattern(cmd_pattern), .cmd_incr(cmd_incr),
        .cmd_verify(cmd_verify), .busy(busy), .done(done),
        .err_count(err_count), .mem_address(mem_address),
        .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // Memory model; bad_en flips bit 0 of one word on read-back.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            bad_en = 0;
    logic [AW-1:0] bad_addr = '0;

    always @(posedge clk) begin
        if (mem_chipselect && mem_write)
            mem[mem_address] <= mem_writedata;
        if (mem_chipselect && !mem_write)
            mem_readdata <= mem[mem_address] ^
                ((bad_en && mem_address == bad_addr) ? 32'h1 : 32'h0);
    end

    typedef struct {
        bit            busy, done, cs, we, chk;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] err;
    } rec_t;

    rec_t          q[$];
    rec_t          r;
    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] hold_err = '0;
    int            done_at;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Compare process: one expected record per cycle while a command
    // runs, quiet idle bus otherwise.
    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            if (q.size() > 0) begin
                r = q.pop_front();
                chk("busy", busy, r.busy);
                chk("done", done, r.done);
                chk("cs", mem_chipselect, r.cs);
                chk("write", mem_write, r.we);
                chk("clken", mem_clken, r.busy);
                chk("be", mem_byteenable, r.cs ? 4'hF : 4'h0);
                if (r.cs) chk("addr", mem_address, r.addr);
                if (r.we) chk("wdata", mem_writedata, r.data);
                if (r.chk) begin
                    chk("err_done", err_count, r.err);
                    hold_err = r.err;
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_cs", mem_chipselect, 0);
                chk("idle_write", mem_write, 0);
                chk("idle_clken", mem_clken, 0);
                chk("idle_err", err_count, hold_err);
            end
        end
    end

    task automatic push_cmd(input logic [AW-1:0] b, input logic [CW-1:0] l,
                            input logic [DW-1:0] p, input bit inc,
                            input bit ver, input int e);
        rec_t x;
        for (int i = 0; i < int'(l); i++) begin
            x = '{busy:1, done:0, cs:1, we:1, chk:0,
                  addr:b + AW'(i), data:p + (inc ? DW'(i) : 0), err:0};
            q.push_back(x);
        end
        if (ver && l != 0) begin
            for (int i = 0; i < int'(l); i++) begin
                x = '{busy:1, done:0, cs:1, we:0, chk:0,
                      addr:b + AW'(i), data:0, err:0};
                q.push_back(x);
            end
            x = '{busy:1, done:0, cs:0, we:0, chk:0, addr:0, data:0, err:0};
            q.push_back(x);
        end
        x = '{busy:1, done:1, cs:0, we:0, chk:1, addr:0, data:0,
              err:CW'(e)};
        q.push_back(x);
    endtask

    // Runs one command; poke>0 pulses a foreign start in that busy cycle.
    task automatic run(input logic [AW-1:0] b, input logic [CW-1:0] l,
                       input logic [DW-1:0] p, input bit inc,
                       input bit ver, input int poke);
        logic [AW-1:0] off;
        int            e, cyc, budget;
        off = bad_addr - b;
        e = (ver && bad_en && l != 0 && int'(off) < int'(l)) ? 1 : 0;
        @(negedge clk);
        push_cmd(b, l, p, inc, ver, e);
        hold_err = '0;
        cmd_base = b; cmd_len = l; cmd_pattern = p;
        cmd_incr = inc; cmd_verify = ver; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        done_at = done ? 1 : 0;
        budget = 2 * int'(l) + 10;
        while (q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done && done_at == 0) done_at = cyc;
            if (cyc == poke) begin
                start = 1'b1;
                cmd_base = AW'($urandom);
                cmd_len = 3;
                cmd_pattern = $urandom;
                cmd_incr = ~inc;
                cmd_verify = ~ver;
            end
            if (cyc == poke + 1) start = 1'b0;
        end
        chk("cmd_drained", q.size(), 0);
        q.delete();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        reset_n = 1'b0;
        start = 0; abort = 0;
        cmd_base = '0; cmd_len = '0; cmd_pattern = '0;
        cmd_incr = 0; cmd_verify = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_writedata, 0);
        chk("rst_err", err_count, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // constant fill, no verify
        run(14'h0, 15'd4, 32'hA5A5A5A5, 0, 0, 0);
        chk("t1_done_cycle", done_at, 5);
        for (int i = 0; i < 4; i++) chk("t1_mem", mem[i], 32'hA5A5A5A5);

        // incrementing fill across the address wrap
        run(14'h3FFE, 15'd4, 32'h10, 1, 0, 0);
        chk("t2_m3ffe", mem[14'h3FFE], 32'h10);
        chk("t2_m3fff", mem[14'h3FFF], 32'h11);
        chk("t2_m0000", mem[14'h0000], 32'h12);
        chk("t2_m0001", mem[14'h0001], 32'h13);

        // verify clean, then with word 3 corrupted
        run(14'h100, 15'd8, 32'h1234_0000, 1, 1, 0);
        chk("t3_clean", err_count, 0);
        chk("t3_latency", done_at, 18);
        bad_en = 1; bad_addr = 14'h103;
        run(14'h100, 15'd8, 32'h1234_0000, 1, 1, 0);
        chk("t3_bad", err_count, 1);
        repeat (3) @(negedge clk);
        chk("t3_hold", err_count, 1);
        bad_en = 0;

        // zero length
        run(14'h5, 15'd0, 32'hFFFF, 1, 1, 0);
        chk("t4_done_cycle", done_at, 1);

        // abort in READ at i=2: cycles 1..8 fill, 9..11 read
        @(negedge clk);
        push_cmd(14'h40, 15'd8, 32'hCAFE0000, 1, 1, 0);
        q = q[0:10];
        hold_err = '0;
        cmd_base = 14'h40; cmd_len = 8; cmd_pattern = 32'hCAFE0000;
        cmd_incr = 1; cmd_verify = 1; start = 1;
        @(negedge clk);
        start = 0;
        repeat (10) @(negedge clk);
        chk("t5_in_read", mem_write, 0);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("t5_cs_low", mem_chipselect, 0);
        chk("t5_no_done", done, 0);
        run(14'h200, 15'd3, 32'h77, 0, 1, 0);
        chk("t5_restart", done_at, 8);

        // async reset in FILL at i=5
        @(negedge clk);
        push_cmd(14'h300, 15'd10, 32'h9, 1, 0, 0);
        hold_err = '0;
        cmd_base = 14'h300; cmd_len = 10; cmd_pattern = 32'h9;
        cmd_incr = 1; cmd_verify = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        chk("t6_in_fill", mem_address, 14'h305);
        reset_n = 0;
        q.delete();
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_cs", mem_chipselect, 0);
        chk("t6_write", mem_write, 0);
        chk("t6_clken", mem_clken, 0);
        chk("t6_addr", mem_address, 0);
        @(negedge clk);
        reset_n = 1;
        run(14'h400, 15'd6, 32'h55, 1, 1, 3);

        // start and abort together in IDLE
        @(negedge clk);
        start = 1; abort = 1; cmd_len = 4;
        @(negedge clk);
        start = 0; abort = 0;
        repeat (3) @(negedge clk);

        // random commands
        for (int n = 0; n < 25; n++) begin
            logic [AW-1:0] b;
            b = AW'($urandom);
            bad_en = ($urandom_range(0, 1) == 1);
            bad_addr = b + AW'($urandom_range(0, 50));
            run(b, CW'($urandom_range(0, 40)), $urandom,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        // full address space, verify, one bad word
        bad_en = 1; bad_addr = 14'h1FFF;
        run(14'h2000, 15'd16384, 32'hF000_0000, 1, 1, 0);
        chk("full_err", err_count, 1);
        chk("full_wrap", mem[14'h1FFF], 32'hF000_3FFF);
        bad_en = 0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
